// File: rtl/hazard_match_pipe.sv
// hazard_match_pipe: E/M/W stage tracker for the hazard unit.
// Carries per-stage valid bit, register addresses and control bits, and
// produces combinational address-match flags used for forwarding and stalls.
// Optional build macro: R15_MATCH_MASK_EN -- when defined, any match whose
// compared source address is 4'hF (PC reads) is suppressed.
module hazard_match_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       RegWriteD,
  input  logic       MemToRegD,
  input  logic       PCSrcD,
  input  logic       FlushE,
  output logic [3:0] RA1E,
  output logic [3:0] RA2E,
  output logic [3:0] WA3E,
  output logic [3:0] WA3M,
  output logic [3:0] WA3W,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic       MemToRegE,
  output logic       PCSrcE,
  output logic       PCSrcM,
  output logic       PCSrcW,
  output logic       Match_1E_M,
  output logic       Match_1E_W,
  output logic       Match_2E_M,
  output logic       Match_2E_W,
  output logic       Match_12D_E
);

  // Execute stage
  logic       r_valid_e;
  logic [3:0] r_ra1_e;
  logic [3:0] r_ra2_e;
  logic [3:0] r_wa3_e;
  logic       r_regwrite_e;
  logic       r_memtoreg_e;
  logic       r_pcsrc_e;

  // Memory stage (only fields consumed downstream are kept)
  logic       r_valid_m;
  logic [3:0] r_wa3_m;
  logic       r_regwrite_m;
  logic       r_pcsrc_m;

  // Writeback stage
  logic       r_valid_w;
  logic [3:0] r_wa3_w;
  logic       r_regwrite_w;
  logic       r_pcsrc_w;

  // Source-address qualifiers for the optional PC-read mask
  logic w_ra1e_ok;
  logic w_ra2e_ok;
  logic w_ra1d_ok;
  logic w_ra2d_ok;

  // Execute stage load: reset clears, flush inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_e    <= 1'b0;
      r_ra1_e      <= 4'h0;
      r_ra2_e      <= 4'h0;
      r_wa3_e      <= 4'h0;
      r_regwrite_e <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_pcsrc_e    <= 1'b0;
    end else if (FlushE) begin
      r_valid_e    <= 1'b0;
      r_ra1_e      <= 4'h0;
      r_ra2_e      <= 4'h0;
      r_wa3_e      <= 4'h0;
      r_regwrite_e <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_pcsrc_e    <= 1'b0;
    end else begin
      r_valid_e    <= 1'b1;
      r_ra1_e      <= RA1D;
      r_ra2_e      <= RA2D;
      r_wa3_e      <= WA3D;
      r_regwrite_e <= RegWriteD;
      r_memtoreg_e <= MemToRegD;
      r_pcsrc_e    <= PCSrcD;
    end
  end

  // Memory stage: unconditional copy of Execute, never stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_m    <= 1'b0;
      r_wa3_m      <= 4'h0;
      r_regwrite_m <= 1'b0;
      r_pcsrc_m    <= 1'b0;
    end else begin
      r_valid_m    <= r_valid_e;
      r_wa3_m      <= r_wa3_e;
      r_regwrite_m <= r_valid_e & r_regwrite_e;
      r_pcsrc_m    <= r_valid_e & r_pcsrc_e;
    end
  end

  // Writeback stage: unconditional copy of Memory, never stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_w    <= 1'b0;
      r_wa3_w      <= 4'h0;
      r_regwrite_w <= 1'b0;
      r_pcsrc_w    <= 1'b0;
    end else begin
      r_valid_w    <= r_valid_m;
      r_wa3_w      <= r_wa3_m;
      r_regwrite_w <= r_valid_m & r_regwrite_m;
      r_pcsrc_w    <= r_valid_m & r_pcsrc_m;
    end
  end

  // PC-read qualifiers: address 4'hF is either masked or an ordinary register
  always_comb begin
`ifdef R15_MATCH_MASK_EN
    w_ra1e_ok = (r_ra1_e != 4'hF);
    w_ra2e_ok = (r_ra2_e != 4'hF);
    w_ra1d_ok = (RA1D != 4'hF);
    w_ra2d_ok = (RA2D != 4'hF);
`else
    w_ra1e_ok = 1'b1;
    w_ra2e_ok = 1'b1;
    w_ra1d_ok = 1'b1;
    w_ra2d_ok = 1'b1;
`endif
  end

  // Match flags: zero-latency compares of current stage registers and D inputs
  always_comb begin
    Match_1E_M  = r_valid_e & r_valid_m & w_ra1e_ok & (r_ra1_e == r_wa3_m);
    Match_2E_M  = r_valid_e & r_valid_m & w_ra2e_ok & (r_ra2_e == r_wa3_m);
    Match_1E_W  = r_valid_e & r_valid_w & w_ra1e_ok & (r_ra1_e == r_wa3_w);
    Match_2E_W  = r_valid_e & r_valid_w & w_ra2e_ok & (r_ra2_e == r_wa3_w);
    Match_12D_E = r_valid_e & ((w_ra1d_ok & (RA1D == r_wa3_e)) |
                               (w_ra2d_ok & (RA2D == r_wa3_e)));
  end

  // Registered outputs; control bits are qualified by their stage valid bit
  always_comb begin
    RA1E      = r_ra1_e;
    RA2E      = r_ra2_e;
    WA3E      = r_wa3_e;
    WA3M      = r_wa3_m;
    WA3W      = r_wa3_w;
    MemToRegE = r_valid_e & r_memtoreg_e;
    PCSrcE    = r_valid_e & r_pcsrc_e;
    RegWriteM = r_valid_m & r_regwrite_m;
    PCSrcM    = r_valid_m & r_pcsrc_m;
    RegWriteW = r_valid_w & r_regwrite_w;
    PCSrcW    = r_valid_w & r_pcsrc_w;
  end

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Testbench for hazard_match_pipe: directed dependency scenarios plus
// randomized traffic, all checked against a history-queue reference model.
module tb_hazard_match_pipe;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemToRegD, PCSrcD, FlushE;
  logic [3:0] RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemToRegE, PCSrcE, PCSrcM, PCSrcW;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;

  int n_chk;
  int n_err;

  hazard_match_pipe dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD),
    .FlushE(FlushE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one entry per instruction slot; index 0 = E, 1 = M, 2 = W.
  // A bubble (flush or reset) is an all-zero, invalid entry.
  typedef struct packed {
    logic       v;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mtr;
    logic       pcs;
  } ins_t;

  ins_t hq[$];

  function automatic bit src_ok(input logic [3:0] a);
`ifdef R15_MATCH_MASK_EN
    return (a != 4'hF);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit addr_hit(input ins_t rd, input logic [3:0] src, input ins_t wr);
    return rd.v && wr.v && src_ok(src) && (src == wr.wa3);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output to the model for the current cycle
  task automatic check_model();
    ins_t e, m, w;
    bit   d_hit;
    e = hq[0]; m = hq[1]; w = hq[2];
    d_hit = e.v && ((src_ok(RA1D) && RA1D == e.wa3) || (src_ok(RA2D) && RA2D == e.wa3));
    chk("RA1E", RA1E, e.ra1);
    chk("RA2E", RA2E, e.ra2);
    chk("WA3E", WA3E, e.wa3);
    chk("WA3M", WA3M, m.wa3);
    chk("WA3W", WA3W, w.wa3);
    chk("MemToRegE", MemToRegE, e.v & e.mtr);
    chk("PCSrcE", PCSrcE, e.v & e.pcs);
    chk("RegWriteM", RegWriteM, m.v & m.rw);
    chk("PCSrcM", PCSrcM, m.v & m.pcs);
    chk("RegWriteW", RegWriteW, w.v & w.rw);
    chk("PCSrcW", PCSrcW, w.v & w.pcs);
    chk("Match_1E_M", Match_1E_M, addr_hit(e, e.ra1, m));
    chk("Match_2E_M", Match_2E_M, addr_hit(e, e.ra2, m));
    chk("Match_1E_W", Match_1E_W, addr_hit(e, e.ra1, w));
    chk("Match_2E_W", Match_2E_W, addr_hit(e, e.ra2, w));
    chk("Match_12D_E", Match_12D_E, d_hit);
  endtask

  // Drive D inputs for this cycle, then check at the falling edge
  task automatic apply(input logic rst, input logic fl,
                       input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input logic rw, input logic mtr, input logic pcs);
    reset = rst; FlushE = fl;
    RA1D = a1; RA2D = a2; WA3D = a3;
    RegWriteD = rw; MemToRegD = mtr; PCSrcD = pcs;
    @(negedge clk);
    check_model();
  endtask

  // Advance one rising edge and shift the model history
  task automatic tick();
    ins_t nw;
    @(posedge clk);
    if (reset) begin
      hq = '{ins_t'(0), ins_t'(0), ins_t'(0)};
    end else begin
      if (FlushE) nw = '0;
      else nw = '{v: 1'b1, ra1: RA1D, ra2: RA2D, wa3: WA3D,
                  rw: RegWriteD, mtr: MemToRegD, pcs: PCSrcD};
      hq.push_front(nw);
      void'(hq.pop_back());
    end
    #1;
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 4'hF;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    hq = '{ins_t'(0), ins_t'(0), ins_t'(0)};
    reset = 1'b1; FlushE = 1'b0;
    RA1D = '0; RA2D = '0; WA3D = '0;
    RegWriteD = 1'b0; MemToRegD = 1'b0; PCSrcD = 1'b0;
    #1;

    // Reset, then the cycle after reset: everything zero
    apply(1, 1, 4'h3, 4'h4, 4'h5, 1, 1, 1); tick();
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    chk("rst_Match_12D_E", Match_12D_E, 0);
    chk("rst_RegWriteW", RegWriteW, 0);
    tick();

    // Back-to-back dependency on r3
    apply(0, 0, 4'h1, 4'h2, 4'h3, 1, 0, 0); tick();
    apply(0, 0, 4'h3, 4'h4, 4'h6, 0, 0, 0); tick();
    apply(0, 0, 4'h8, 4'h9, 4'hA, 0, 0, 0);
    chk("b2b_Match_1E_M", Match_1E_M, 1);
    tick();
    apply(0, 0, 4'hB, 4'hC, 4'hD, 0, 0, 0);
    chk("b2b_Match_1E_W", Match_1E_W, 0);
    tick();

    // Load-use on r5
    apply(0, 0, 4'h0, 4'h1, 4'h5, 1, 1, 0); tick();
    apply(0, 0, 4'h0, 4'h5, 4'h2, 0, 0, 0);
    chk("lu_Match_12D_E", Match_12D_E, 1);
    chk("lu_MemToRegE", MemToRegE, 1);
    tick();

    // Flush drops a writer of r7
    apply(0, 1, 4'h1, 4'h2, 4'h7, 1, 0, 0); tick();
    apply(0, 0, 4'h7, 4'h7, 4'h0, 0, 0, 0);
    chk("fl_Match_12D_E", Match_12D_E, 0);
    chk("fl_WA3E", WA3E, 0);
    tick();
    apply(0, 0, 4'h1, 4'h1, 4'h1, 0, 0, 0); tick();
    apply(0, 0, 4'h2, 4'h2, 4'h2, 0, 0, 0);
    chk("fl_RegWriteW", RegWriteW, 0);
    chk("fl_Match_2E_W", Match_2E_W, 0);
    tick();

    // PCSrc pulse walks E -> M -> W one cycle each
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1); tick();
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    chk("pc_E1", PCSrcE, 1); chk("pc_M0", PCSrcM, 0);
    tick();
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    chk("pc_E0", PCSrcE, 0); chk("pc_M1", PCSrcM, 1);
    tick();
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    chk("pc_M0b", PCSrcM, 0); chk("pc_W1", PCSrcW, 1);
    tick();
    apply(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    chk("pc_W0", PCSrcW, 0);
    tick();

    // Reset mid-stream with three writers in flight
    apply(0, 0, 4'h1, 4'h2, 4'h1, 1, 0, 1); tick();
    apply(0, 0, 4'h1, 4'h2, 4'h2, 1, 0, 0); tick();
    apply(0, 0, 4'h1, 4'h2, 4'h1, 1, 1, 0); tick();
    apply(1, 0, 4'h1, 4'h2, 4'h3, 1, 0, 0); tick();
    apply(0, 0, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    chk("mr_RegWriteM", RegWriteM, 0);
    chk("mr_WA3W", WA3W, 0);
    chk("mr_Match_12D_E", Match_12D_E, 0);
    chk("mr_Match_1E_M", Match_1E_M, 0);
    tick();

    // R15 handling
    apply(0, 0, 4'h0, 4'h0, 4'hF, 1, 0, 0); tick();
    apply(0, 0, 4'hF, 4'h1, 4'h2, 0, 0, 0);
`ifdef R15_MATCH_MASK_EN
    chk("r15_Match_12D_E", Match_12D_E, 0);
`else
    chk("r15_Match_12D_E", Match_12D_E, 1);
`endif
    tick();
    apply(0, 0, 4'h3, 4'h3, 4'h3, 0, 0, 0);
`ifdef R15_MATCH_MASK_EN
    chk("r15_Match_1E_M", Match_1E_M, 0);
`else
    chk("r15_Match_1E_M", Match_1E_M, 1);
`endif
    tick();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            rnd_addr(), rnd_addr(), rnd_addr(),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog: the stimulus is clock-paced, so this only guards against a hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
